pio_cmd_responder: RTL and testbench

- Board-side responder for the CPU's 8-bit PIO pair.
- Consumes command bytes the CPU writes to its PIO output port and returns response bytes on the PIO input port, using a toggle handshake.
- Holds an 8-bit LED register and a small byte FIFO.
- Also serves as a bench responder with programmable latency for firmware bring-up.

---
 rtl/pio_cmd_responder.sv | 176 +++++++++++++++++
 tb/tb_pio_cmd_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pio_cmd_responder.sv
// pio_cmd_responder: board-side responder for an 8-bit PIO pair.
// The CPU toggles pio_out[7] to issue a command. After a programmable delay
// the command executes and pio_in[7] echoes the toggle as the acknowledge.
// Commands drive an 8-bit LED register and a small 5-bit-wide byte FIFO.
module pio_cmd_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int RESP_DELAY = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] pio_out,
  output logic [7:0] pio_in,
  output logic [7:0] led,
  output logic       busy
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [7:0] DELAY_C = 8'(RESP_DELAY);

  localparam logic [1:0] OP_SETLED = 2'b00;
  localparam logic [1:0] OP_PUSH   = 2'b01;
  localparam logic [1:0] OP_POP    = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_EXEC = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         req_q;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         pio_in_q, pio_in_d;
  logic [7:0]         led_q, led_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]         count_q, count_d;

  // FIFO storage; deliberately not reset, occupancy is tracked by count_q
  logic [4:0]         mem [FIFO_DEPTH];
  logic               wr_en;
  logic [4:0]         head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               rsp_err;
  logic [5:0]         rsp_data;
  logic [4:0]         arg;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == 4'd0);
  assign head       = mem[rd_ptr_q];
  assign arg        = cmd_q[4:0];

  // Next-state and command execution logic
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    pio_in_d = pio_in_q;
    led_d    = led_q;
    busy_d   = busy_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = 6'd0;

    case (state_q)
      ST_IDLE: begin
        // A toggle mismatch against the last ack is a new request
        if (req_q[7] != pio_in_q[7]) begin
          cmd_d   = req_q;
          cnt_d   = DELAY_C;
          busy_d  = 1'b1;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_EXEC: begin
        case (cmd_q[6:5])
          OP_SETLED: begin
            led_d    = {3'b000, arg};
            rsp_data = {1'b0, arg};
          end
          OP_PUSH: begin
            if (!fifo_full) begin
              wr_en    = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
              count_d  = count_q + 4'd1;
              rsp_data = {2'b00, count_q + 4'd1};
            end else begin
              rsp_err  = 1'b1;
              rsp_data = {2'b00, count_q};
            end
          end
          OP_POP: begin
            if (!fifo_empty) begin
              rsp_data = {1'b0, head};
              rd_ptr_d = rd_ptr_q + PTR_W'(1);
              count_d  = count_q - 4'd1;
            end else begin
              rsp_err  = 1'b1;
              rsp_data = 6'd0;
            end
          end
          OP_STATUS: begin
            rsp_data = {fifo_full, fifo_empty, count_q};
          end
          default: begin
            rsp_data = 6'd0;
          end
        endcase
        pio_in_d = {cmd_q[7], rsp_err, rsp_data};
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state, registered outputs and input synchroniser stage
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      req_q    <= 8'd0;
      cmd_q    <= 8'd0;
      cnt_q    <= 8'd0;
      pio_in_q <= 8'd0;
      led_q    <= 8'd0;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= pio_out;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      pio_in_q <= pio_in_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO write port
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= arg;
    end
  end

  assign pio_in = pio_in_q;
  assign led    = led_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Testbench for pio_cmd_responder: directed commands, expected responses
// queued at issue time and checked by an independent monitor on each ack.
module tb_pio_cmd_responder;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] pio_out;
  logic [7:0] pio_in;
  logic [7:0] led;
  logic       busy;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q [$];
  logic       last_ack  = 1'b0;
  logic       tog       = 1'b0;

  pio_cmd_responder #(
    .FIFO_DEPTH(8),
    .RESP_DELAY(4)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .pio_out      (pio_out),
    .pio_in       (pio_in),
    .led          (led),
    .busy         (busy)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
  endtask

  // Monitor: every ack toggle is a response; compare with the oldest expectation
  always @(negedge clk_clk) begin
    logic [7:0] e;
    if (!reset_reset_n) begin
      last_ack = 1'b0;
    end else if (pio_in[7] != last_ack) begin
      last_ack = pio_in[7];
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rsp: got 0x%02h expected none", pio_in);
      end else begin
        e = exp_q.pop_front();
        check("rsp", pio_in, e);
        $display("rsp 0x%02h (expected 0x%02h)", pio_in, e);
      end
    end
  end

  task automatic wait_ack(input string name);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_clk);
      if (pio_in[7] == tog) done = 1;
    end
    total_cnt++;
    if (done) pass_cnt++;
    else $display("FAIL %s_timeout: got ack %0b expected %0b", name, pio_in[7], tog);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a,
                          input logic e_err, input logic [5:0] e_data, input string name);
    tog     = ~tog;
    pio_out = {tog, op, a};
    exp_q.push_back({tog, e_err, e_data});
    wait_ack(name);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    pio_out       = 8'h00;
    repeat (3) @(negedge clk_clk);
    check("rst_pio_in", pio_in, 8'h00);
    reset_reset_n = 1'b1;

    // Idle with no toggle: nothing may happen
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_clk);
      check("idle_pio_in", pio_in, 8'h00);
      check("idle_led", led, 8'h00);
      check("idle_busy", {7'd0, busy}, 8'h00);
    end

    // SETLED 0x95 with exact latency and busy timing
    tog     = 1'b1;
    pio_out = 8'h95;
    exp_q.push_back(8'h95);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_clk);
      @(negedge clk_clk);
      check($sformatf("lat_busy_e%0d", k), {7'd0, busy}, (k >= 1 && k <= 6) ? 8'h01 : 8'h00);
      if (k == 6) check("lat_pio_in_early", pio_in, 8'h00);
      if (k == 7) begin
        check("lat_pio_in", pio_in, 8'h95);
        check("lat_led", led, 8'h15);
      end
    end

    // Fill the FIFO, overflow, then status
    for (int i = 1; i <= 8; i++)
      send_cmd(2'b01, 5'(i), 1'b0, 6'(i), "push");
    send_cmd(2'b01, 5'h09, 1'b1, 6'd8, "push_full");
    send_cmd(2'b11, 5'h00, 1'b0, 6'h28, "status_full");

    // Drain in order, underflow, then status
    for (int i = 1; i <= 8; i++)
      send_cmd(2'b10, 5'h00, 1'b0, 6'(i), "pop");
    send_cmd(2'b10, 5'h00, 1'b1, 6'd0, "pop_empty");
    send_cmd(2'b11, 5'h00, 1'b0, 6'h10, "status_empty");

    // Pointer wrap past the end of storage
    send_cmd(2'b01, 5'h1E, 1'b0, 6'd1, "push_wrap");
    send_cmd(2'b10, 5'h00, 1'b0, 6'h1E, "pop_wrap");
    check("led_kept", led, 8'h15);

    // Argument changed during WAIT must not affect the captured command
    tog     = ~tog;
    pio_out = {tog, 2'b00, 5'h0A};
    exp_q.push_back({tog, 1'b0, 6'h0A});
    repeat (3) @(negedge clk_clk);
    pio_out[4:0] = 5'h1F;
    wait_ack("setled_stable");
    check("led_stable", led, 8'h0A);

    // Reset asserted in WAIT of a PUSH: abandoned, outputs clear asynchronously
    tog     = ~tog;
    pio_out = {tog, 2'b01, 5'h03};
    repeat (3) @(negedge clk_clk);
    check("busy_in_wait", {7'd0, busy}, 8'h01);
    #1 reset_reset_n = 1'b0;
    #1;
    check("async_pio_in", pio_in, 8'h00);
    check("async_led", led, 8'h00);
    check("async_busy", {7'd0, busy}, 8'h00);
    pio_out = 8'h00;
    tog     = 1'b0;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);
    send_cmd(2'b11, 5'h00, 1'b0, 6'h10, "status_after_rst");

    repeat (4) @(negedge clk_clk);
    check("queue_left", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
